// File: rtl/riscv_pkg.sv
// Shared definitions for the load/store unit: Funct3 encodings, LSU state type,
// default data-memory base address and access-size helpers.
package riscv_pkg;

    localparam logic [31:0] LSU_BASE_ADDR = 32'h0000_2000;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } access_size_t;

    // Unknown encodings fall back to a full word access.
    function automatic access_size_t access_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return SZ_BYTE;
            F3_H, F3_HU: return SZ_HALF;
            F3_W:        return SZ_WORD;
            default:     return SZ_WORD;
        endcase
    endfunction

    function automatic logic [1:0] align_lo(input access_size_t sz, input logic [1:0] lo);
        case (sz)
            SZ_BYTE: return lo;
            SZ_HALF: return {lo[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic is_misaligned(input access_size_t sz, input logic [1:0] lo);
        case (sz)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return lo[0];
            default: return |lo;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: store byte enables and replicated write data,
// load lane select with sign/zero extension.
module lsu_lane_align
    import riscv_pkg::*;
(
    input  access_size_t st_size,
    input  logic [1:0]   st_lo,
    input  logic [31:0]  st_data,
    output logic [3:0]   st_be,
    output logic [31:0]  st_wdata,
    input  logic [2:0]   ld_funct3,
    input  logic [1:0]   ld_lo,
    input  logic [31:0]  ld_word,
    output logic [31:0]  ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = st_data;
        case (st_size)
            SZ_BYTE: begin
                st_be    = 4'b0001 << st_lo;
                st_wdata = {4{st_data[7:0]}};
            end
            SZ_HALF: begin
                st_be    = st_lo[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{st_data[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = st_data;
            end
        endcase
    end

    always_comb begin
        ld_byte = ld_word[{ld_lo, 3'b000} +: 8];
        ld_half = ld_lo[1] ? ld_word[31:16] : ld_word[15:0];
        case (ld_funct3)
            F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   ld_data = {24'b0, ld_byte};
            F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
            F3_HU:   ld_data = {16'b0, ld_half};
            default: ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory stage: synchronous-read word memory with a one-cycle load stall.
// Optional misaligned-access trapping is enabled with LSU_MISALIGN_TRAP_EN.
module load_store_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = LSU_BASE_ADDR,
    parameter int          DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  Funct3,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
`ifdef LSU_MISALIGN_TRAP_EN
    output logic        MisalignErr,
`endif
    output lsu_state_t  lsu_state_dbg
);

    localparam int          AW       = $clog2(DEPTH_WORDS);
    localparam logic [31:0] END_ADDR = BASE_ADDR + 32'(4 * DEPTH_WORDS);
    localparam logic [AW-1:0] BASE_IDX = BASE_ADDR[AW+1:2];

    lsu_state_t    state;
    logic [1:0]    lo_q;
    logic [2:0]    funct3_q;
    logic [31:0]   rd_word;
    logic [31:0]   mem [DEPTH_WORDS];

    access_size_t  size;
    logic [1:0]    lo_eff;
    logic [AW-1:0] idx;
    logic          in_range;
    logic          misaligned;
    logic          rd_issue;
    logic          st_req;
    logic          wr_en;
    logic [3:0]    st_be;
    logic [31:0]   st_wdata;
    logic [31:0]   ld_data;

    assign size     = access_size(Funct3);
    assign lo_eff   = align_lo(size, ALUResult[1:0]);
    assign in_range = (ALUResult >= BASE_ADDR) && (ALUResult < END_ADDR);
    // Modulo arithmetic on the index bits is exact whenever in_range holds.
    assign idx      = ALUResult[AW+1:2] - BASE_IDX;

`ifdef LSU_MISALIGN_TRAP_EN
    assign misaligned = is_misaligned(size, ALUResult[1:0]);
`else
    assign misaligned = 1'b0;
`endif

    // Handshake: MemRead is a level request held by the datapath while Stall=1;
    // a load is accepted in IDLE, Stall is raised that same cycle, and ReadData
    // is valid for exactly the following (RESP) cycle. Stores never stall, and a
    // concurrent MemRead suppresses the store.
    assign rd_issue = (state == IDLE) && MemRead;
    assign st_req   = MemWrite && !MemRead;
    assign wr_en    = rst && st_req && in_range && !misaligned;
    assign Stall    = rst && rd_issue;

    assign lsu_state_dbg = state;

    lsu_lane_align u_lane_align (
        .st_size   (size),
        .st_lo     (lo_eff),
        .st_data   (WriteData),
        .st_be     (st_be),
        .st_wdata  (st_wdata),
        .ld_funct3 (funct3_q),
        .ld_lo     (lo_q),
        .ld_word   (rd_word),
        .ld_data   (ld_data)
    );

    assign ReadData = (state == RESP) ? ld_data : 32'h0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            lo_q     <= 2'b00;
            funct3_q <= 3'b000;
`ifdef LSU_MISALIGN_TRAP_EN
            MisalignErr <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (MemRead) begin
                        state    <= RESP;
                        lo_q     <= lo_eff;
                        funct3_q <= Funct3;
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
`ifdef LSU_MISALIGN_TRAP_EN
            if ((rd_issue || st_req) && misaligned) begin
                MisalignErr <= 1'b1;
            end
`endif
        end
    end

    // Memory contents survive reset, so this block has no reset term.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (st_be[b]) begin
                    mem[idx][8*b +: 8] <= st_wdata[8*b +: 8];
                end
            end
        end
        if (rd_issue) begin
            rd_word <= (in_range && !misaligned) ? mem[idx] : 32'h0;
        end
    end

endmodule
